// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the load/store unit memory front end.
package lsu_mem_ctrl_pkg;
    localparam int REG_LEN = 32;
    localparam int BE_W    = REG_LEN / 8;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b011,
        SZ_HU = 3'b100
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;
endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core request, memory port and load-result signals of the LSU front end.
interface lsu_mem_ctrl_if
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int W = REG_LEN
);
    logic            req_valid;
    logic            req_we;
    logic [2:0]      req_type;
    logic [W-1:0]    req_addr;
    logic [W-1:0]    req_wdata;
    logic            req_ready;
    logic            stall;
    logic            mem_req;
    logic [W-1:0]    mem_addr;
    logic            mem_we;
    logic [BE_W-1:0] mem_be;
    logic [W-1:0]    mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [W-1:0]    mem_rdata;
    logic [W-1:0]    rd_d;
    logic [2:0]      sel_type;
    logic [1:0]      sel_addr_old;
    logic            ld_valid;
    logic            misaligned;
    logic            bus_err;

    // LSU side
    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, stall, mem_req, mem_addr, mem_we, mem_be, mem_wdata,
               rd_d, sel_type, sel_addr_old, ld_valid, misaligned, bus_err
    );

    // core + memory environment side
    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, stall, mem_req, mem_addr, mem_we, mem_be, mem_wdata,
               rd_d, sel_type, sel_addr_old, ld_valid, misaligned, bus_err
    );
endinterface

// File: rtl/lsu_mem_ctrl_be_gen.sv
// Byte-enable / store-lane generation and alignment check for one access.
module lsu_mem_ctrl_be_gen
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [2:0]         typ,
    input  logic [1:0]         off,
    input  logic [REG_LEN-1:0] wdata,
    output logic [BE_W-1:0]    be,
    output logic [REG_LEN-1:0] wd,
    output logic               reject
);
    always_comb begin
        be     = '0;
        wd     = wdata;
        reject = 1'b0;
        case (typ)
            SZ_B, SZ_BU: begin
                be = BE_W'(1) << off;
                wd = {4{wdata[7:0]}};
            end
            SZ_H, SZ_HU: begin
                be     = BE_W'(3) << off;
                wd     = {2{wdata[15:0]}};
                reject = off[0];
            end
            SZ_W: begin
                be     = '1;
                reject = (off != 2'b00);
            end
            default: reject = 1'b1;
        endcase
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// LSU front end: accepts one load/store, runs the req/gnt/rvalid handshake,
// captures the raw load word, and aborts on timeout.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input logic           clk,
    input logic           rst_n,
    lsu_mem_ctrl_if.slave bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      pend_type;
    logic [1:0]      pend_off;
    logic [BE_W-1:0] be;
    logic [REG_LEN-1:0] wd;
    logic            reject;
    logic            accept;
    logic            timeout_hit;

    lsu_mem_ctrl_be_gen u_be_gen (
        .typ    (bus.req_type),
        .off    (bus.req_addr[1:0]),
        .wdata  (bus.req_wdata),
        .be     (be),
        .wd     (wd),
        .reject (reject)
    );

    assign accept      = (state == ST_IDLE) && bus.req_valid;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    assign bus.req_ready = (state == ST_IDLE);
    // a store completes on its grant cycle, so the core is released right there
    assign bus.stall = accept
                     | ((state == ST_REQ) && !(bus.mem_we && bus.mem_gnt))
                     | (state == ST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            pend_type        <= '0;
            pend_off         <= '0;
            bus.mem_req      <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_we       <= 1'b0;
            bus.mem_be       <= '0;
            bus.mem_wdata    <= '0;
            bus.rd_d         <= '0;
            bus.sel_type     <= '0;
            bus.sel_addr_old <= '0;
            bus.ld_valid     <= 1'b0;
            bus.misaligned   <= 1'b0;
            bus.bus_err      <= 1'b0;
        end else begin
            bus.ld_valid   <= 1'b0;
            bus.misaligned <= 1'b0;
            bus.bus_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        cnt <= '0;
                        if (reject) begin
                            bus.misaligned <= 1'b1;
                        end else begin
                            state         <= ST_REQ;
                            bus.mem_req   <= 1'b1;
                            bus.mem_addr  <= {bus.req_addr[REG_LEN-1:2], 2'b00};
                            bus.mem_we    <= bus.req_we;
                            bus.mem_be    <= be;
                            bus.mem_wdata <= wd;
                            pend_type     <= bus.req_type;
                            pend_off      <= bus.req_addr[1:0];
                        end
                    end
                end
                ST_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        state       <= bus.mem_we ? ST_IDLE : ST_WAIT;
                    end else if (timeout_hit) begin
                        bus.mem_req <= 1'b0;
                        bus.bus_err <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (bus.mem_rvalid) begin
                        // type/offset are published together with the word so they stay coherent
                        bus.rd_d         <= bus.mem_rdata;
                        bus.sel_type     <= pend_type;
                        bus.sel_addr_old <= pend_off;
                        bus.ld_valid     <= 1'b1;
                        state            <= ST_DONE;
                    end else if (timeout_hit) begin
                        bus.bus_err <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: vector table, random traffic against a
// byte-level reference model, and hand sequences for reset/timeout/back-to-back.
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.W(32)) b ();
    lsu_mem_ctrl_if #(.W(32)) b2 ();

    lsu_mem_ctrl #(.TIMEOUT(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(b));
    lsu_mem_ctrl #(.TIMEOUT(4))  u_dut_to (.clk(clk), .rst_n(rst_n), .bus(b2));

    typedef struct {
        string       tag;
        logic        we;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gw;
        int          rw;
        logic        rej;
        logic [3:0]  be;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // Reference: access size in bytes, natural alignment, lane i carries byte (i mod size).
    function automatic void model(input logic [2:0] typ, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic rej,
                                  output logic [3:0] be, output logic [31:0] wd);
        int sz;
        int off;
        sz  = (typ == 3'd0 || typ == 3'd3) ? 1 : (typ == 3'd1 || typ == 3'd4) ? 2 :
              (typ == 3'd2) ? 4 : 0;
        off = int'(addr % 4);
        rej = (sz == 0) ? 1'b1 : ((off % sz) != 0);
        be  = '0;
        wd  = '0;
        if (!rej) begin
            for (int i = 0; i < 4; i++) begin
                be[i]       = (i >= off) && (i < off + sz);
                wd[8*i +: 8] = wdata[8*(i % sz) +: 8];
            end
        end
    endfunction

    task automatic run_txn(input vec_t v);
        @(negedge clk);
        b.req_valid = 1'b1; b.req_we = v.we; b.req_type = v.typ;
        b.req_addr = v.addr; b.req_wdata = v.wdata;
        #1 chk({v.tag, " accept stall"}, 32'(b.stall), 1);
        @(negedge clk);
        b.req_valid = 1'b0; b.req_addr = $urandom; b.req_wdata = $urandom;
        if (v.rej) begin
            chk({v.tag, " misaligned pulse"}, 32'(b.misaligned), 1);
            chk({v.tag, " rej mem_req"}, 32'(b.mem_req), 0);
            #1 chk({v.tag, " rej stall"}, 32'(b.stall), 0);
            @(negedge clk);
            chk({v.tag, " misaligned end"}, 32'(b.misaligned), 0);
            chk({v.tag, " rej mem_req2"}, 32'(b.mem_req), 0);
            return;
        end
        chk({v.tag, " no misaligned"}, 32'(b.misaligned), 0);
        chk({v.tag, " mem_addr"}, b.mem_addr, {v.addr[31:2], 2'b00});
        chk({v.tag, " mem_be"}, 32'(b.mem_be), 32'(v.be));
        chk({v.tag, " mem_we"}, 32'(b.mem_we), 32'(v.we));
        if (v.we) chk({v.tag, " mem_wdata"}, b.mem_wdata, v.wd);
        for (int i = 0; i <= v.gw; i++) begin
            chk({v.tag, " mem_req held"}, 32'(b.mem_req), 1);
            b.mem_gnt    = (i == v.gw);
            b.mem_rvalid = (i < v.gw) ? 1'($urandom) : 1'b0;
            #1 chk({v.tag, " req stall"}, 32'(b.stall), 32'(!(v.we && i == v.gw)));
            @(negedge clk);
        end
        b.mem_gnt = 1'b0; b.mem_rvalid = 1'b0;
        chk({v.tag, " mem_req dropped"}, 32'(b.mem_req), 0);
        if (v.we) begin
            chk({v.tag, " st ready"}, 32'(b.req_ready), 1);
            chk({v.tag, " st no ld_valid"}, 32'(b.ld_valid), 0);
            return;
        end
        for (int i = 0; i <= v.rw; i++) begin
            b.mem_rvalid = (i == v.rw);
            b.mem_rdata  = (i == v.rw) ? v.rdata : $urandom;
            #1 chk({v.tag, " wait ld_valid"}, 32'(b.ld_valid), 0);
            chk({v.tag, " wait stall"}, 32'(b.stall), 1);
            @(negedge clk);
        end
        b.mem_rvalid = 1'b0;
        chk({v.tag, " ld_valid"}, 32'(b.ld_valid), 1);
        chk({v.tag, " rd_d"}, b.rd_d, v.rdata);
        chk({v.tag, " sel_type"}, 32'(b.sel_type), 32'(v.typ));
        chk({v.tag, " sel_addr_old"}, 32'(b.sel_addr_old), 32'(v.addr[1:0]));
        chk({v.tag, " done stall"}, 32'(b.stall), 0);
        chk({v.tag, " done ready"}, 32'(b.req_ready), 0);
        @(negedge clk);
        chk({v.tag, " ld_valid end"}, 32'(b.ld_valid), 0);
        chk({v.tag, " idle ready"}, 32'(b.req_ready), 1);
    endtask

    initial begin
        vec_t v;
        {b.req_valid, b.req_we, b.mem_gnt, b.mem_rvalid} = '0;
        b.req_type = '0; b.req_addr = '0; b.req_wdata = '0; b.mem_rdata = '0;
        {b2.req_valid, b2.req_we, b2.mem_gnt, b2.mem_rvalid} = '0;
        b2.req_type = '0; b2.req_addr = '0; b2.req_wdata = '0; b2.mem_rdata = '0;

        vecs[0]  = '{"ldW104",  1'b0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 0, 0, 1'b0, 4'b1111, 32'h0};
        vecs[1]  = '{"stB203",  1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0,        3, 0, 1'b0, 4'b1000, 32'hA5A5A5A5};
        vecs[2]  = '{"ldH11",   1'b0, 3'b001, 32'h11,  32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0};
        vecs[3]  = '{"ldHU12",  1'b0, 3'b100, 32'h12,  32'h0,        32'h12345678, 1, 2, 1'b0, 4'b1100, 32'h0};
        vecs[4]  = '{"stH002",  1'b1, 3'b001, 32'h2,   32'hCAFEBEEF, 32'h0,        0, 0, 1'b0, 4'b1100, 32'hBEEFBEEF};
        vecs[5]  = '{"stW008",  1'b1, 3'b010, 32'h8,   32'h01020304, 32'h0,        1, 0, 1'b0, 4'b1111, 32'h01020304};
        vecs[6]  = '{"stW009",  1'b1, 3'b010, 32'h9,   32'h01020304, 32'h0,        0, 0, 1'b1, 4'b0000, 32'h0};
        vecs[7]  = '{"ldT5",    1'b0, 3'b101, 32'h0,   32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0};
        vecs[8]  = '{"stBU101", 1'b1, 3'b011, 32'h101, 32'hFFFFFF3C, 32'h0,        2, 0, 1'b0, 4'b0010, 32'h3C3C3C3C};
        vecs[9]  = '{"ldB003",  1'b0, 3'b000, 32'h3,   32'h0,        32'h87654321, 2, 3, 1'b0, 4'b1000, 32'h0};
        vecs[10] = '{"stHU001", 1'b1, 3'b100, 32'h1,   32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0};

        repeat (3) @(negedge clk);
        chk("rst req_ready", 32'(b.req_ready), 1);
        chk("rst mem_req", 32'(b.mem_req), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init stall", 32'(b.stall), 0);
        chk("init ld_valid", 32'(b.ld_valid), 0);
        chk("init misaligned", 32'(b.misaligned), 0);
        chk("init bus_err", 32'(b.bus_err), 0);
        chk("init rd_d", b.rd_d, 0);
        chk("init sel_type", 32'(b.sel_type), 0);
        chk("init mem_be", 32'(b.mem_be), 0);

        foreach (vecs[i]) run_txn(vecs[i]);

        for (int k = 0; k < 40; k++) begin
            v.tag   = $sformatf("rnd%0d", k);
            v.we    = 1'($urandom);
            v.typ   = 3'($urandom);
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.gw    = int'($urandom_range(0, 4));
            v.rw    = int'($urandom_range(0, 4));
            model(v.typ, v.addr, v.wdata, v.rej, v.be, v.wd);
            run_txn(v);
        end

        // request held high across a busy load: second one waits for IDLE
        @(negedge clk);
        b.req_valid = 1'b1; b.req_we = 1'b0; b.req_type = 3'b010; b.req_addr = 32'h40;
        #1 chk("hold accept stall", 32'(b.stall), 1);
        @(negedge clk);
        b.req_we = 1'b1; b.req_addr = 32'h80; b.req_wdata = 32'h11223344;
        chk("hold mem_addr first", b.mem_addr, 32'h40);
        chk("hold ready busy", 32'(b.req_ready), 0);
        b.mem_gnt = 1'b1;
        @(negedge clk);
        b.mem_gnt = 1'b0; b.mem_rvalid = 1'b1; b.mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        b.mem_rvalid = 1'b0;
        chk("hold ld_valid", 32'(b.ld_valid), 1);
        chk("hold rd_d", b.rd_d, 32'h0BADF00D);
        chk("hold done ready", 32'(b.req_ready), 0);
        #1 chk("hold done stall", 32'(b.stall), 0);
        @(negedge clk);
        chk("hold idle ready", 32'(b.req_ready), 1);
        chk("hold idle mem_req", 32'(b.mem_req), 0);
        #1 chk("hold 2nd accept stall", 32'(b.stall), 1);
        @(negedge clk);
        b.req_valid = 1'b0;
        chk("hold 2nd mem_req", 32'(b.mem_req), 1);
        chk("hold 2nd mem_addr", b.mem_addr, 32'h80);
        chk("hold 2nd mem_we", 32'(b.mem_we), 1);
        chk("hold 2nd wdata", b.mem_wdata, 32'h11223344);
        b.mem_gnt = 1'b1;
        #1 chk("hold 2nd gnt stall", 32'(b.stall), 0);
        @(negedge clk);
        b.mem_gnt = 1'b0;
        chk("hold 2nd done", 32'(b.mem_req), 0);

        // timeout on the TIMEOUT=4 instance: never granted, then granted but no rvalid
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            b2.req_valid = 1'b1; b2.req_we = 1'b0; b2.req_type = 3'b010; b2.req_addr = 32'h10;
            @(negedge clk);
            b2.req_valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("to%0d bus_err early", g), 32'(b2.bus_err), 0);
                if (g == 0 || i == 0) chk($sformatf("to%0d mem_req", g), 32'(b2.mem_req), 1);
                b2.mem_gnt = (g == 1 && i == 0);
                @(negedge clk);
                b2.mem_gnt = 1'b0;
            end
            chk($sformatf("to%0d bus_err", g), 32'(b2.bus_err), 1);
            chk($sformatf("to%0d mem_req off", g), 32'(b2.mem_req), 0);
            chk($sformatf("to%0d ready", g), 32'(b2.req_ready), 1);
            chk($sformatf("to%0d no ld_valid", g), 32'(b2.ld_valid), 0);
            b2.mem_rvalid = 1'b1; b2.mem_rdata = 32'hFEEDFACE;
            @(negedge clk);
            b2.mem_rvalid = 1'b0;
            chk($sformatf("to%0d bus_err end", g), 32'(b2.bus_err), 0);
            chk($sformatf("to%0d late rvalid", g), 32'(b2.ld_valid), 0);
        end

        // asynchronous reset while waiting for read data
        @(negedge clk);
        b.req_valid = 1'b1; b.req_we = 1'b0; b.req_type = 3'b001; b.req_addr = 32'h62;
        @(negedge clk);
        b.req_valid = 1'b0;
        chk("rstw mem_req", 32'(b.mem_req), 1);
        b.mem_gnt = 1'b1;
        @(negedge clk);
        b.mem_gnt = 1'b0;
        chk("rstw in wait stall", 32'(b.stall), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw stall", 32'(b.stall), 0);
        chk("rstw ready", 32'(b.req_ready), 1);
        chk("rstw mem_addr", b.mem_addr, 0);
        chk("rstw mem_be", 32'(b.mem_be), 0);
        chk("rstw rd_d", b.rd_d, 0);
        chk("rstw sel_type", 32'(b.sel_type), 0);
        chk("rstw sel_addr_old", 32'(b.sel_addr_old), 0);
        @(negedge clk);
        rst_n = 1'b1;
        b.mem_rvalid = 1'b1; b.mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        b.mem_rvalid = 1'b0;
        chk("rstw late ld_valid", 32'(b.ld_valid), 0);
        chk("rstw late rd_d", b.rd_d, 0);
        chk("rstw late ready", 32'(b.req_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
